gps_round_seq: RTL and testbench

//  Sequences one GPS code-generation round on the gps / gps_mock_tss datapath.
//  - Pulses the core soft reset (sync_rst_in_dut), then issues a one-cycle startRound.
//  - Waits for l_code_valid under a timeout and captures ca/p/l codes into holding registers.
//  - Refuses to run until the LLKI key is loaded (llkid_key_complete); sits between the register interface and the core.

---
 rtl/gps_round_seq.sv | 117 +++++++++++
 tb/tb_gps_round_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gps_round_seq.sv
// gps_round_seq: sequences one GPS code-generation round (core soft reset, startRound, timed capture of ca/p/l codes).
// Optional back-to-back rounds are enabled by defining GPS_ROUND_SEQ_AUTORUN_EN.
module gps_round_seq #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AUTORUN_GAP    = 64
) (
    input  logic         sys_clk_50,
    input  logic         rst,
    input  logic         start_req,
    input  logic         abort,
    input  logic         key_ready,
    input  logic         autorun_en,
    input  logic         l_code_valid,
    input  logic [12:0]  ca_code,
    input  logic [127:0] p_code,
    input  logic [127:0] l_code,
    output logic         dut_rst,
    output logic         start_round,
    output logic [12:0]  ca_code_q,
    output logic [127:0] p_code_q,
    output logic [127:0] l_code_q,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         key_err,
    output logic [15:0]  round_count
);
`ifdef GPS_ROUND_SEQ_AUTORUN_EN
    typedef enum logic [2:0] {IDLE, RST_DUT, START, WAIT, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RST_DUT, START, WAIT} state_t;
    logic unused_cfg;
    assign unused_cfg = autorun_en ^ (AUTORUN_GAP == 0);
`endif
    state_t      state, nxt;
    logic [15:0] cnt;
    logic        go, capture, tmo, kset;
    // State register; cnt restarts on every state change so it times the current state
    always_ff @(posedge sys_clk_50 or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + 16'd1;
        end
    // Next-state and event decode; abort, then key loss, override everything in a running round
    always_comb begin
        nxt     = state;
        go      = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        kset    = 1'b0;
        case (state)
            IDLE: begin
                go   = start_req & key_ready;
                kset = start_req & ~key_ready;
                nxt  = go ? RST_DUT : IDLE;
            end
            RST_DUT: nxt = (cnt == 16'(RST_CYCLES - 1)) ? START : RST_DUT;
            START:   nxt = WAIT;
            WAIT: begin
                capture = l_code_valid;
                tmo     = ~l_code_valid & (cnt == 16'(TIMEOUT_CYCLES - 1));
`ifdef GPS_ROUND_SEQ_AUTORUN_EN
                nxt = capture ? (autorun_en ? GAP : IDLE) : tmo ? IDLE : WAIT;
`else
                nxt = (capture | tmo) ? IDLE : WAIT;
`endif
            end
`ifdef GPS_ROUND_SEQ_AUTORUN_EN
            GAP: begin
                go  = autorun_en & (cnt == 16'(AUTORUN_GAP - 1));
                nxt = !autorun_en ? IDLE : go ? RST_DUT : GAP;
            end
`endif
            default: nxt = IDLE;
        endcase
        if (state != IDLE && (abort || !key_ready)) begin
            nxt     = IDLE;
            go      = 1'b0;
            capture = 1'b0;
            tmo     = 1'b0;
            kset    = ~abort;
        end
    end
    // Capture registers, sticky status flags and saturating round counter
    always_ff @(posedge sys_clk_50 or posedge rst)
        if (rst) begin
            ca_code_q   <= '0;
            p_code_q    <= '0;
            l_code_q    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            key_err     <= 1'b0;
            round_count <= '0;
        end else begin
            if (go) begin
                done        <= 1'b0;
                timeout_err <= 1'b0;
                key_err     <= 1'b0;
            end
            if (capture) begin
                ca_code_q   <= ca_code;
                p_code_q    <= p_code;
                l_code_q    <= l_code;
                done        <= 1'b1;
                round_count <= (&round_count) ? round_count : round_count + 16'd1;
            end
            if (tmo) timeout_err <= 1'b1;
            if (kset) key_err <= 1'b1;
        end
    assign dut_rst     = (state == RST_DUT);
    assign start_round = (state == START);
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_gps_round_seq.sv
// tb_gps_round_seq: randomized self-checking bench for gps_round_seq (default build, autorun disabled).
module tb_gps_round_seq;
    logic         clk = 1'b0;
    logic         rst, start_req, abort, key_ready, autorun_en, l_code_valid;
    logic [12:0]  ca_code;
    logic [127:0] p_code, l_code;
    logic         dut_rst, start_round, busy, done, timeout_err, key_err;
    logic [12:0]  ca_code_q;
    logic [127:0] p_code_q, l_code_q;
    logic [15:0]  round_count;
    int           n_cmp = 0, n_bad = 0;
    logic [12:0]  exp_ca;
    logic [127:0] exp_p, exp_l;
    logic         exp_done, exp_to, exp_ke;
    logic [15:0]  exp_rc;

    gps_round_seq #(.RST_CYCLES(4), .TIMEOUT_CYCLES(16), .AUTORUN_GAP(8)) dut (
        .sys_clk_50(clk), .rst(rst), .start_req(start_req), .abort(abort), .key_ready(key_ready),
        .autorun_en(autorun_en), .l_code_valid(l_code_valid), .ca_code(ca_code), .p_code(p_code),
        .l_code(l_code), .dut_rst(dut_rst), .start_round(start_round), .ca_code_q(ca_code_q),
        .p_code_q(p_code_q), .l_code_q(l_code_q), .busy(busy), .done(done),
        .timeout_err(timeout_err), .key_err(key_err), .round_count(round_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_ca = '0; exp_p = '0; exp_l = '0;
        exp_done = 0; exp_to = 0; exp_ke = 0; exp_rc = '0;
    endtask

    task automatic test_reset();
        rst = 1; start_req = 0; abort = 0; key_ready = 1; autorun_en = 0; l_code_valid = 0;
        ca_code = '0; p_code = '0; l_code = '0;
        model_reset();
        tick(); tick();
        n_cmp++;
        if ({dut_rst, start_round, busy, done, timeout_err, key_err} !== 6'b0 ||
            ca_code_q !== '0 || p_code_q !== '0 || l_code_q !== '0 || round_count !== '0) begin
            n_bad++;
            $display("FAIL reset: flags=%b rc=%0h ca=%0h want all 0",
                     {dut_rst, start_round, busy, done, timeout_err, key_err}, round_count, ca_code_q);
        end
        rst = 0;
        tick();
    endtask

    // One round: valid at WAIT cycle vd (vd>=16 means never); ab/kl put abort / key loss on the event cycle.
    task automatic run_round(input int vd, input bit ab, input bit kl, input logic [12:0] ca);
        logic [127:0] p = rnd128(), l = rnd128();
        int ev = (vd < 16) ? vd : 15;
        int last = (ab || kl) ? ev : ((vd < 16) ? vd : 15);
        exp_done = 0; exp_to = 0; exp_ke = 0;
        key_ready = 1; start_req = 1;
        tick();
        start_req = 0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (dut_rst !== 1'b1 || start_round !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_phase c%0d: dut_rst=%b start_round=%b busy=%b want 1 0 1", i, dut_rst, start_round, busy);
            end
            tick();
        end
        n_cmp++;
        if (start_round !== 1'b1 || dut_rst !== 1'b0 || {done, timeout_err, key_err} !== 3'b0) begin
            n_bad++;
            $display("FAIL start_phase: start_round=%b dut_rst=%b flags=%b want 1 0 000", start_round, dut_rst, {done, timeout_err, key_err});
        end
        tick();
        for (int w = 0; w < 16; w++) begin
            n_cmp++;
            if (busy !== 1'b1 || start_round !== 1'b0) begin
                n_bad++;
                $display("FAIL wait w%0d: busy=%b start_round=%b want 1 0", w, busy, start_round);
            end
            start_req = (w == 0);
            if (w == vd) begin
                l_code_valid = 1; ca_code = ca; p_code = p; l_code = l;
            end
            abort = ab && (w == ev);
            key_ready = !(kl && (w == ev));
            tick();
            start_req = 0; abort = 0; l_code_valid = 0; key_ready = 1;
            ca_code = 13'($urandom); p_code = rnd128(); l_code = rnd128();
            if (w == last) break;
        end
        if (ab) ;
        else if (kl) exp_ke = 1;
        else if (vd < 16) begin
            exp_ca = ca; exp_p = p; exp_l = l; exp_done = 1;
            exp_rc = (exp_rc == 16'hFFFF) ? exp_rc : exp_rc + 1;
        end else exp_to = 1;
        n_cmp++;
        if (busy !== 1'b0 || dut_rst !== 1'b0 || done !== exp_done || timeout_err !== exp_to || key_err !== exp_ke) begin
            n_bad++;
            $display("FAIL end_flags vd=%0d ab=%0d kl=%0d: busy,done,to,ke=%b%b%b%b want 0%b%b%b",
                     vd, ab, kl, busy, done, timeout_err, key_err, exp_done, exp_to, exp_ke);
        end
        n_cmp++;
        if (ca_code_q !== exp_ca || p_code_q !== exp_p || l_code_q !== exp_l || round_count !== exp_rc) begin
            n_bad++;
            $display("FAIL end_data vd=%0d: ca=%0h rc=%0d want ca=%0h rc=%0d", vd, ca_code_q, round_count, exp_ca, exp_rc);
        end
        tick();
    endtask

    task automatic test_key_err();
        key_ready = 0; start_req = 1;
        tick();
        start_req = 0;
        exp_ke = 1;
        n_cmp++;
        if (key_err !== 1'b1 || busy !== 1'b0 || dut_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL key_err: key_err=%b busy=%b dut_rst=%b want 1 0 0", key_err, busy, dut_rst);
        end
        tick();
        n_cmp++;
        if (dut_rst !== 1'b0 || start_round !== 1'b0 || done !== exp_done) begin
            n_bad++;
            $display("FAIL key_err_idle: dut_rst=%b start_round=%b done=%b want 0 0 %b", dut_rst, start_round, done, exp_done);
        end
        key_ready = 1;
        tick();
    endtask

    task automatic test_valid_outside();
        for (int i = 0; i < 3; i++) begin
            l_code_valid = 1; ca_code = 13'($urandom); p_code = rnd128(); l_code = rnd128();
            tick();
        end
        l_code_valid = 0;
        tick();
        n_cmp++;
        if (ca_code_q !== exp_ca || p_code_q !== exp_p || round_count !== exp_rc || done !== exp_done || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_outside: ca=%0h rc=%0d done=%b want ca=%0h rc=%0d done=%b", ca_code_q, round_count, done, exp_ca, exp_rc, exp_done);
        end
    endtask

    task automatic test_rst_mid();
        start_req = 1;
        tick();
        start_req = 0;
        tick();
        n_cmp++;
        if (dut_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: dut_rst=%b want 1", dut_rst);
        end
        rst = 1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_rst !== 1'b0 || busy !== 1'b0 || round_count !== 16'd0 || ca_code_q !== '0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: dut_rst=%b busy=%b rc=%0d ca=%0h done=%b want all 0", dut_rst, busy, round_count, ca_code_q, done);
        end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            int mode = $urandom_range(0, 2);
            run_round($urandom_range(0, 20), mode == 1, mode == 2, 13'($urandom));
        end
    endtask

    initial begin
        test_reset();
        run_round(3, 0, 0, 13'h1ABC);
        run_round(16, 0, 0, 13'h0555);
        test_key_err();
        run_round(2, 1, 0, 13'h0F0F);
        run_round(15, 0, 0, 13'h1234);
        run_round(5, 0, 1, 13'h0777);
        run_round(16, 1, 0, 13'h0001);
        test_valid_outside();
        test_random();
        test_rst_mid();
        run_round(0, 0, 0, 13'h1FFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
